// File: rtl/tlb_access_sched_if.sv
// Bundle of requester handshakes, TLB port set and lookup response for tlb_access_sched.
interface tlb_access_sched_if #(
  parameter int unsigned ASID_WIDTH = 1
);
  // Instruction lookup requester
  logic                  i_valid_i;
  logic [31:0]           i_vaddr_i;
  logic [ASID_WIDTH-1:0] i_asid_i;
  logic                  i_ready_o;
  // Data lookup requester
  logic                  d_valid_i;
  logic [31:0]           d_vaddr_i;
  logic [ASID_WIDTH-1:0] d_asid_i;
  logic                  d_ready_o;
  // PTW refill requester
  logic                  u_valid_i;
  logic [19:0]           u_vpn_i;
  logic [8:0]            u_asid_i;
  logic                  u_is_4M_i;
  logic [31:0]           u_content_i;
  logic                  u_ready_o;
  // SFENCE flush requester
  logic                  f_valid_i;
  logic [31:0]           f_vaddr_i;
  logic [ASID_WIDTH-1:0] f_asid_i;
  logic                  f_ready_o;
  // TLB port set
  logic                  tlb_flush_o;
  logic [62:0]           tlb_update_o;
  logic                  tlb_lu_access_o;
  logic [31:0]           tlb_lu_vaddr_o;
  logic [ASID_WIDTH-1:0] tlb_lu_asid_o;
  logic [31:0]           tlb_vaddr_flush_o;
  logic [ASID_WIDTH-1:0] tlb_asid_flush_o;
  logic                  tlb_lu_hit_i;
  logic                  tlb_lu_is_4M_i;
  logic [31:0]           tlb_lu_content_i;
  // Registered lookup response
  logic                  resp_valid_o;
  logic                  resp_id_o;
  logic                  resp_hit_o;
  logic                  resp_is_4M_o;
  logic [31:0]           resp_content_o;
  logic [15:0]           miss_cnt_o;

  // Scheduler side
  modport slave (
    input  i_valid_i, i_vaddr_i, i_asid_i,
    input  d_valid_i, d_vaddr_i, d_asid_i,
    input  u_valid_i, u_vpn_i, u_asid_i, u_is_4M_i, u_content_i,
    input  f_valid_i, f_vaddr_i, f_asid_i,
    input  tlb_lu_hit_i, tlb_lu_is_4M_i, tlb_lu_content_i,
    output i_ready_o, d_ready_o, u_ready_o, f_ready_o,
    output tlb_flush_o, tlb_update_o, tlb_lu_access_o, tlb_lu_vaddr_o, tlb_lu_asid_o,
    output tlb_vaddr_flush_o, tlb_asid_flush_o,
    output resp_valid_o, resp_id_o, resp_hit_o, resp_is_4M_o, resp_content_o, miss_cnt_o
  );

  // Requester / TLB side
  modport master (
    output i_valid_i, i_vaddr_i, i_asid_i,
    output d_valid_i, d_vaddr_i, d_asid_i,
    output u_valid_i, u_vpn_i, u_asid_i, u_is_4M_i, u_content_i,
    output f_valid_i, f_vaddr_i, f_asid_i,
    output tlb_lu_hit_i, tlb_lu_is_4M_i, tlb_lu_content_i,
    input  i_ready_o, d_ready_o, u_ready_o, f_ready_o,
    input  tlb_flush_o, tlb_update_o, tlb_lu_access_o, tlb_lu_vaddr_o, tlb_lu_asid_o,
    input  tlb_vaddr_flush_o, tlb_asid_flush_o,
    input  resp_valid_o, resp_id_o, resp_hit_o, resp_is_4M_o, resp_content_o, miss_cnt_o
  );
endinterface

// File: rtl/tlb_access_sched.sv
// Arbiter/sequencer sharing one TLB lookup/update/flush port set between
// instruction lookup, data lookup, PTW refill and SFENCE flush requesters.
module tlb_access_sched #(
  parameter int unsigned ASID_WIDTH   = 1,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic               clk_i,
  input logic               rst_i,
  tlb_access_sched_if.slave bus
);

  typedef enum logic [1:0] {IDLE, FLUSH, FLUSH_BUB} state_e;

  state_e                state_q, state_d;
  logic                  rr_q;            // 0: I wins a tie, 1: D wins a tie
  logic [2:0]            starve_i_q, starve_d_q;
  logic                  promo_i, promo_d;
  logic                  grant_f, grant_u, grant_i, grant_d, grant_lu;

  logic                  flush_q;
  logic [31:0]           flush_vaddr_q;
  logic [ASID_WIDTH-1:0] flush_asid_q;

  logic                  resp_valid_q, resp_id_q, resp_hit_q, resp_is_4M_q;
  logic [31:0]           resp_content_q;
  logic [15:0]           miss_cnt_q;

  assign promo_i  = bus.i_valid_i && (32'(starve_i_q) >= STARVE_LIMIT);
  assign promo_d  = bus.d_valid_i && (32'(starve_d_q) >= STARVE_LIMIT);
  assign grant_lu = grant_i | grant_d;

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state: a flush grant walks through the flush cycle and one bubble
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (bus.f_valid_i) state_d = FLUSH;
      FLUSH:     state_d = FLUSH_BUB;
      FLUSH_BUB: state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Grant selection: flush, then starved lookups, then refill, then round-robin lookups
  always_comb begin
    grant_f = 1'b0;
    grant_u = 1'b0;
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (state_q == IDLE) begin
      if (bus.f_valid_i) begin
        grant_f = 1'b1;
      end else if (promo_i && promo_d) begin
        grant_i = !rr_q;
        grant_d = rr_q;
      end else if (promo_i || promo_d) begin
        grant_i = promo_i;
        grant_d = promo_d;
      end else if (bus.u_valid_i) begin
        grant_u = 1'b1;
      end else if (bus.i_valid_i && bus.d_valid_i) begin
        grant_i = !rr_q;
        grant_d = rr_q;
      end else begin
        grant_i = bus.i_valid_i;
        grant_d = bus.d_valid_i;
      end
    end
  end

  assign bus.f_ready_o = grant_f;
  assign bus.u_ready_o = grant_u;
  assign bus.i_ready_o = grant_i;
  assign bus.d_ready_o = grant_d;

  assign bus.tlb_update_o    = grant_u ? {1'b1, bus.u_is_4M_i, bus.u_vpn_i, bus.u_asid_i, bus.u_content_i}
                                       : '0;
  assign bus.tlb_lu_access_o = grant_lu;
  assign bus.tlb_lu_vaddr_o  = grant_i ? bus.i_vaddr_i : (grant_d ? bus.d_vaddr_i : '0);
  assign bus.tlb_lu_asid_o   = grant_i ? bus.i_asid_i  : (grant_d ? bus.d_asid_i  : '0);

  // Round-robin pointer moves to the other lookup port after each lookup grant
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)        rr_q <= 1'b0;
    else if (grant_i) rr_q <= 1'b1;
    else if (grant_d) rr_q <= 1'b0;
  end

  // Starve counters: count denied pending cycles, saturating, cleared on grant or idle
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      starve_i_q <= '0;
      starve_d_q <= '0;
    end else begin
      if (!bus.i_valid_i || grant_i) starve_i_q <= '0;
      else if (starve_i_q != '1)     starve_i_q <= starve_i_q + 3'd1;
      if (!bus.d_valid_i || grant_d) starve_d_q <= '0;
      else if (starve_d_q != '1)     starve_d_q <= starve_d_q + 3'd1;
    end
  end

  // Flush strobe and target registers; reset aborts an in-flight flush
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      flush_q       <= 1'b0;
      flush_vaddr_q <= '0;
      flush_asid_q  <= '0;
    end else begin
      flush_q <= grant_f;
      if (grant_f) begin
        flush_vaddr_q <= bus.f_vaddr_i;
        flush_asid_q  <= bus.f_asid_i;
      end
    end
  end

  // Lookup response capture and saturating miss counter
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      resp_valid_q   <= 1'b0;
      resp_id_q      <= 1'b0;
      resp_hit_q     <= 1'b0;
      resp_is_4M_q   <= 1'b0;
      resp_content_q <= '0;
      miss_cnt_q     <= '0;
    end else begin
      resp_valid_q <= grant_lu;
      if (grant_lu) begin
        resp_id_q      <= grant_d;
        resp_hit_q     <= bus.tlb_lu_hit_i;
        resp_is_4M_q   <= bus.tlb_lu_is_4M_i;
        resp_content_q <= bus.tlb_lu_content_i;
      end
      if (grant_lu && !bus.tlb_lu_hit_i && (miss_cnt_q != '1))
        miss_cnt_q <= miss_cnt_q + 16'd1;
    end
  end

  assign bus.tlb_flush_o       = flush_q;
  assign bus.tlb_vaddr_flush_o = flush_vaddr_q;
  assign bus.tlb_asid_flush_o  = flush_asid_q;
  assign bus.resp_valid_o      = resp_valid_q;
  assign bus.resp_id_o         = resp_id_q;
  assign bus.resp_hit_o        = resp_hit_q;
  assign bus.resp_is_4M_o      = resp_is_4M_q;
  assign bus.resp_content_o    = resp_content_q;
  assign bus.miss_cnt_o        = miss_cnt_q;

endmodule

// File: tb/tb_tlb_access_sched.sv
// Bench for tlb_access_sched: directed scenarios plus random traffic, every cycle
// compared against a rule-level scheduler model and a small associative TLB model.
module tb_tlb_access_sched;
  localparam int unsigned AW = 1;
  localparam int unsigned SL = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tlb_access_sched_if #(.ASID_WIDTH(AW)) bus ();

  tlb_access_sched #(.ASID_WIDTH(AW), .STARVE_LIMIT(SL)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        hit;
    logic        m4;
    logic [31:0] pte;
  } tlb_res_t;

  // TLB contents seen by the environment
  logic        e_val  [8];
  logic [19:0] e_vpn  [8];
  logic [8:0]  e_asid [8];
  logic        e_4m   [8];
  logic [31:0] e_pte  [8];
  int          e_wr;

  // Scheduler reference state
  int              m_blk;      // cycles during which nothing may be granted
  logic            m_flush;
  logic [31:0]     m_fva;
  logic [AW-1:0]   m_fasid;
  int              m_st [2];   // denied-cycle counts, 0 = I, 1 = D
  int              m_rr;       // lookup port favoured on a tie
  logic            m_rv, m_rid, m_rhit, m_r4m;
  logic [31:0]     m_rpte;
  int              m_miss;

  // Values carried from the sampling point to the clock edge
  int              s_w;
  int              s_lv [2];
  tlb_res_t        s_res;
  logic [31:0]     s_fin_va;
  logic [AW-1:0]   s_fin_asid;
  logic [62:0]     s_upd;
  logic            s_fl;
  logic [31:0]     s_fl_va;
  logic [AW-1:0]   s_fl_asid;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic tlb_res_t tlb_find(input logic [31:0] va, input logic [AW-1:0] asid);
    tlb_res_t r;
    r = '0;
    for (int e = 0; e < 8; e++) begin
      if (e_val[e] && (e_asid[e] == 9'(asid)) &&
          (e_4m[e] ? (e_vpn[e][19:10] == va[31:22]) : (e_vpn[e] == va[31:12]))) begin
        r.hit = 1'b1;
        r.m4  = e_4m[e];
        r.pte = e_pte[e];
      end
    end
    return r;
  endfunction

  // 0 none, 1 F, 2 U, 3 I, 4 D
  function automatic int pick_winner();
    int lv [2];
    lv[0] = int'(bus.i_valid_i);
    lv[1] = int'(bus.d_valid_i);
    if (m_blk != 0) return 0;
    if (bus.f_valid_i) return 1;
    // pass 0: starved lookups, pass 1: refill, pass 2: any pending lookup
    for (int pass = 0; pass < 3; pass++) begin
      if (pass == 1) begin
        if (bus.u_valid_i) return 2;
      end else begin
        for (int k = 0; k < 2; k++) begin
          int p;
          p = (m_rr + k) % 2;
          if (lv[p] != 0 && (pass == 2 || m_st[p] >= int'(SL))) return 3 + p;
        end
      end
    end
    return 0;
  endfunction

  task automatic model_reset();
    m_blk = 0; m_flush = 1'b0; m_fva = '0; m_fasid = '0;
    m_st[0] = 0; m_st[1] = 0; m_rr = 0;
    m_rv = 1'b0; m_rid = 1'b0; m_rhit = 1'b0; m_r4m = 1'b0; m_rpte = '0; m_miss = 0;
  endtask

  task automatic idle_inputs();
    bus.i_valid_i = 1'b0; bus.i_vaddr_i = '0; bus.i_asid_i = '0;
    bus.d_valid_i = 1'b0; bus.d_vaddr_i = '0; bus.d_asid_i = '0;
    bus.u_valid_i = 1'b0; bus.u_vpn_i = '0; bus.u_asid_i = '0; bus.u_is_4M_i = 1'b0; bus.u_content_i = '0;
    bus.f_valid_i = 1'b0; bus.f_vaddr_i = '0; bus.f_asid_i = '0;
  endtask

  // Sample point: drive the TLB answer, compare every output against the model
  task automatic tick_a(output int w);
    logic [62:0]   eu;
    logic [31:0]   la;
    logic [AW-1:0] lasid;
    tlb_res_t      r;
    @(negedge clk);
    r = tlb_find(bus.tlb_lu_vaddr_o, bus.tlb_lu_asid_o);
    bus.tlb_lu_hit_i = r.hit; bus.tlb_lu_is_4M_i = r.m4; bus.tlb_lu_content_i = r.pte;
    w = pick_winner();
    chk("grants", 64'({bus.f_ready_o, bus.u_ready_o, bus.d_ready_o, bus.i_ready_o}),
        64'({w == 1, w == 2, w == 4, w == 3}));
    eu = '0;
    if (w == 2)
      eu = (63'(1) << 62) | (63'(bus.u_is_4M_i) << 61) | (63'(bus.u_vpn_i) << 41) |
           (63'(bus.u_asid_i) << 32) | 63'(bus.u_content_i);
    chk("tlb_update", 64'(bus.tlb_update_o), 64'(eu));
    la    = (w == 3) ? bus.i_vaddr_i : (w == 4) ? bus.d_vaddr_i : '0;
    lasid = (w == 3) ? bus.i_asid_i  : (w == 4) ? bus.d_asid_i  : '0;
    chk("tlb_lookup", 64'({bus.tlb_lu_access_o, bus.tlb_lu_asid_o, bus.tlb_lu_vaddr_o}),
        64'({w >= 3, lasid, la}));
    chk("flush_regs", 64'({bus.tlb_flush_o, bus.tlb_asid_flush_o, bus.tlb_vaddr_flush_o}),
        64'({m_flush, m_fasid, m_fva}));
    chk("response", 64'({bus.resp_valid_o, bus.resp_id_o, bus.resp_hit_o, bus.resp_is_4M_o, bus.resp_content_o}),
        64'({m_rv, m_rid, m_rhit, m_r4m, m_rpte}));
    chk("miss_cnt", 64'(bus.miss_cnt_o), 64'(m_miss));
    s_w = w;
    s_lv[0] = int'(bus.i_valid_i); s_lv[1] = int'(bus.d_valid_i);
    s_res = tlb_find(la, lasid);
    s_fin_va = bus.f_vaddr_i; s_fin_asid = bus.f_asid_i;
    s_upd = bus.tlb_update_o;
    s_fl = bus.tlb_flush_o; s_fl_va = bus.tlb_vaddr_flush_o; s_fl_asid = bus.tlb_asid_flush_o;
  endtask

  // Clock edge: advance model and TLB contents
  task automatic tick_b();
    @(posedge clk);
    #1;
    if (s_w >= 3) begin
      m_rv = 1'b1; m_rid = (s_w == 4); m_rhit = s_res.hit; m_r4m = s_res.m4; m_rpte = s_res.pte;
      if (!s_res.hit && m_miss < 65535) m_miss++;
    end else begin
      m_rv = 1'b0;
    end
    for (int p = 0; p < 2; p++) begin
      if (s_lv[p] == 0 || s_w == 3 + p) m_st[p] = 0;
      else if (m_st[p] < 7) m_st[p]++;
    end
    if (s_w == 3) m_rr = 1;
    else if (s_w == 4) m_rr = 0;
    m_flush = (s_w == 1);
    if (s_w == 1) begin
      m_fva = s_fin_va; m_fasid = s_fin_asid; m_blk = 2;
    end else if (m_blk > 0) begin
      m_blk--;
    end
    if (s_upd[62]) begin
      e_val[e_wr] = 1'b1; e_4m[e_wr] = s_upd[61]; e_vpn[e_wr] = s_upd[60:41];
      e_asid[e_wr] = s_upd[40:32]; e_pte[e_wr] = s_upd[31:0];
      e_wr = (e_wr + 1) % 8;
    end
    if (s_fl) begin
      for (int e = 0; e < 8; e++) begin
        if (s_fl_va == 32'd0) begin
          if (s_fl_asid == '0 || e_asid[e] == 9'(s_fl_asid)) e_val[e] = 1'b0;
        end else if (e_vpn[e] == s_fl_va[31:12]) begin
          e_val[e] = 1'b0;
        end
      end
    end
  endtask

  initial begin
    int w;
    int miss_before;
    logic [19:0] pool [4];
    pool[0] = 20'h10000; pool[1] = 20'h10111; pool[2] = 20'h12345; pool[3] = 20'h2ABCD;
    for (int e = 0; e < 8; e++) begin
      e_val[e] = 1'b0; e_vpn[e] = '0; e_asid[e] = '0; e_4m[e] = 1'b0; e_pte[e] = '0;
    end
    e_wr = 0;
    idle_inputs();
    bus.tlb_lu_hit_i = 1'b0; bus.tlb_lu_is_4M_i = 1'b0; bus.tlb_lu_content_i = '0;
    model_reset();

    // Reset values
    rst = 1'b1;
    #2;
    chk("rst_outputs", 64'({bus.tlb_flush_o, bus.resp_valid_o, bus.resp_id_o, bus.resp_hit_o,
                            bus.resp_is_4M_o, bus.tlb_lu_access_o, bus.tlb_update_o[0]}), 64'd0);
    chk("rst_flush_va", 64'(bus.tlb_vaddr_flush_o), 64'd0);
    chk("rst_resp_pte", 64'(bus.resp_content_o), 64'd0);
    chk("rst_miss", 64'(bus.miss_cnt_o), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Refill then lookup in the next cycle
    bus.u_valid_i = 1'b1; bus.u_vpn_i = 20'h12345; bus.u_asid_i = 9'd1;
    bus.u_is_4M_i = 1'b0; bus.u_content_i = 32'hDEADBEEF;
    tick_a(w);
    chk("refill_packet", 64'(bus.tlb_update_o), 64'h4246_8A01_DEAD_BEEF);
    tick_b();
    idle_inputs();
    bus.i_valid_i = 1'b1; bus.i_vaddr_i = 32'h12345000; bus.i_asid_i = 1'b1;
    tick_a(w);
    chk("update_one_cycle", 64'(bus.tlb_update_o), 64'd0);
    tick_b();
    idle_inputs();
    tick_a(w);
    chk("lookup_resp", 64'({bus.resp_valid_o, bus.resp_id_o, bus.resp_hit_o, bus.resp_content_o}),
        64'({1'b1, 1'b0, 1'b1, 32'hDEADBEEF}));
    tick_b();

    // Flush with a pending D lookup
    bus.f_valid_i = 1'b1; bus.f_vaddr_i = '0; bus.f_asid_i = '0;
    bus.d_valid_i = 1'b1; bus.d_vaddr_i = 32'h12345000; bus.d_asid_i = 1'b1;
    tick_a(w);
    chk("flush_N", 64'({bus.f_ready_o, bus.d_ready_o}), 64'b10);
    tick_b();
    bus.f_valid_i = 1'b0;
    tick_a(w);
    chk("flush_N1", 64'({bus.tlb_flush_o, bus.d_ready_o}), 64'b10);
    tick_b();
    tick_a(w);
    chk("flush_N2", 64'({bus.tlb_flush_o, bus.d_ready_o}), 64'b00);
    tick_b();
    miss_before = m_miss;
    tick_a(w);
    chk("flush_N3", 64'(bus.d_ready_o), 64'd1);
    tick_b();
    idle_inputs();
    tick_a(w);
    chk("post_flush_miss", 64'({bus.resp_id_o, bus.resp_hit_o}), 64'b10);
    chk("miss_incr", 64'(bus.miss_cnt_o), 64'(miss_before + 1));
    tick_b();

    // Round-robin between I and D
    bus.i_valid_i = 1'b1; bus.i_vaddr_i = 32'h10000040;
    bus.d_valid_i = 1'b1; bus.d_vaddr_i = 32'h10111080;
    for (int k = 0; k < 4; k++) begin
      tick_a(w);
      chk("rr_grant", 64'({bus.d_ready_o, bus.i_ready_o}), (k % 2 == 1) ? 64'b10 : 64'b01);
      if (k > 0) chk("rr_resp_id", 64'(bus.resp_id_o), 64'((k - 1) % 2));
      tick_b();
    end
    idle_inputs();
    tick_a(w);
    chk("rr_resp_id", 64'(bus.resp_id_o), 64'd1);
    tick_b();

    // Starvation: U and I both held
    bus.u_valid_i = 1'b1; bus.u_vpn_i = 20'h10111; bus.u_asid_i = 9'd0; bus.u_content_i = 32'h0000_1111;
    bus.i_valid_i = 1'b1; bus.i_vaddr_i = 32'h10111000; bus.i_asid_i = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick_a(w);
      chk("starve_seq", 64'({bus.u_ready_o, bus.i_ready_o}), (k == 4) ? 64'b01 : 64'b10);
      tick_b();
    end
    idle_inputs();

    // Reset in the middle of a flush
    bus.f_valid_i = 1'b1; bus.f_vaddr_i = 32'h10000000; bus.f_asid_i = 1'b1;
    tick_a(w);
    tick_b();
    idle_inputs();
    tick_a(w);
    chk("flush_active", 64'(bus.tlb_flush_o), 64'd1);
    #1 rst = 1'b1;
    #1;
    chk("rst_mid_flush", 64'({bus.tlb_flush_o, bus.resp_valid_o}), 64'b00);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    bus.i_valid_i = 1'b1; bus.i_vaddr_i = 32'h2ABCD000;
    bus.d_valid_i = 1'b1; bus.d_vaddr_i = 32'h12345000;
    tick_a(w);
    chk("first_after_rst", 64'({bus.d_ready_o, bus.i_ready_o}), 64'b01);
    tick_b();

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      bus.f_valid_i   = ($urandom_range(0, 19) == 0);
      bus.f_vaddr_i   = ($urandom_range(0, 1) == 0) ? 32'd0 : {pool[$urandom_range(0, 3)], 12'd0};
      bus.f_asid_i    = AW'($urandom_range(0, 1));
      bus.u_valid_i   = ($urandom_range(0, 2) == 0);
      bus.u_vpn_i     = pool[$urandom_range(0, 3)];
      bus.u_asid_i    = 9'($urandom_range(0, 1));
      bus.u_is_4M_i   = ($urandom_range(0, 3) == 0);
      bus.u_content_i = $urandom;
      bus.i_valid_i   = ($urandom_range(0, 2) != 0);
      bus.i_vaddr_i   = {pool[$urandom_range(0, 3)], 12'($urandom)};
      bus.i_asid_i    = AW'($urandom_range(0, 1));
      bus.d_valid_i   = ($urandom_range(0, 2) != 0);
      bus.d_vaddr_i   = {pool[$urandom_range(0, 3)], 12'($urandom)};
      bus.d_asid_i    = AW'($urandom_range(0, 1));
      tick_a(w);
      tick_b();
    end

    // Miss counter saturation with a never-refilled page
    idle_inputs();
    bus.i_valid_i = 1'b1; bus.i_vaddr_i = 32'hFFFFF000;
    for (int n = 0; n < 70000 && m_miss < 65534; n++) begin
      tick_a(w);
      tick_b();
    end
    tick_a(w);
    chk("miss_at_fffe", 64'(bus.miss_cnt_o), 64'hFFFE);
    tick_b();
    tick_a(w);
    tick_b();
    tick_a(w);
    tick_b();
    idle_inputs();
    tick_a(w);
    chk("miss_saturated", 64'(bus.miss_cnt_o), 64'hFFFF);
    tick_b();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
